// File: rtl/decode_stage_hazard.sv
// decode_stage_hazard
//   MIPS ID stage for a 5-stage pipeline. It contains:
//     - a register file with write-through from WB,
//     - the main control decode,
//     - jump and branch resolution inside ID,
//     - load-use and branch-operand hazard detection,
//     - the ID/EX pipeline register,
//     - a sticky halt.
//
// Optional feature macro: ID_BRANCH_FWD_EN
//   When defined, a branch operand that matches a non-load MEM destination takes i_mem_data
//   instead of stalling. When undefined, every MEM dependency of a branch source stalls and
//   i_mem_data is ignored.
//
// Ports
//   i_clk, i_reset            clock (rising edge); asynchronous active-low reset
//   i_valid, i_pc4,           IF/ID contents
//     i_instruction
//   i_flush                   squash: load a bubble into ID/EX
//   i_wb_*                    register-file write port
//   i_ex_*, i_mem_*           EX/MEM destination info used for hazards; i_mem_data is used
//                             for forwarding
//   o_stall, o_jump,          combinational fetch control
//     o_jump_addr
//   o_halt                    sticky halt flag
//   o_valid, o_RA, o_RB,      ID/EX register outputs
//     o_imm, o_instr, o_ctrl
//   o_ctrl bit layout:
//     [10]   wb_write
//     [9]    mem_to_reg (1 = ALU result)
//     [8]    mem_read
//     [7]    mem_write
//     [6]    mem_unsigned
//     [5:4]  mem_size
//     [3]    alu_src
//     [2]    reg_dst
//     [1:0]  alu_op
module decode_stage_hazard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [31:0]       i_pc4,
  input  logic [31:0]       i_instruction,
  input  logic              i_flush,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_reg,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_we,
  input  logic [REG_AW-1:0] i_ex_dst,
  input  logic              i_mem_read,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_stall,
  output logic              o_jump,
  output logic [31:0]       o_jump_addr,
  output logic              o_halt,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_RA,
  output logic [DATA_W-1:0] o_RB,
  output logic [DATA_W-1:0] o_imm,
  output logic [31:0]       o_instr,
  output logic [10:0]       o_ctrl
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpLwu     = 6'h27;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2B;
  localparam logic [5:0] FnJr      = 6'h08;
  localparam logic [5:0] FnJalr    = 6'h09;

  // ---------------------------------------------------------------------------------------------
  // Field extraction and decode
  // ---------------------------------------------------------------------------------------------
  logic [5:0]        op, funct;
  logic [REG_AW-1:0] rs_idx, rt_idx;

  assign op     = i_instruction[31:26];
  assign funct  = i_instruction[5:0];
  assign rs_idx = REG_AW'(i_instruction[25:21]);
  assign rt_idx = REG_AW'(i_instruction[20:16]);

  logic is_special, is_jr, is_jalr, is_alu_r, is_j, is_jal, is_beq, is_bne;
  logic is_ialu, is_load, is_store, is_halt, is_zext, rt_src;

  assign is_halt    = (i_instruction == 32'hFFFF_FFFF);
  assign is_special = (op == OpSpecial);
  assign is_jr      = is_special && (funct == FnJr);
  assign is_jalr    = is_special && (funct == FnJalr);
  assign is_alu_r   = is_special && !is_jr && !is_jalr;
  assign is_j       = (op == OpJ);
  assign is_jal     = (op == OpJal);
  assign is_beq     = (op == OpBeq);
  assign is_bne     = (op == OpBne);
  assign is_ialu    = (op[5:3] == 3'b001);
  assign is_load    = (op == OpLb) || (op == OpLh) || (op == OpLw) ||
                      (op == OpLbu) || (op == OpLhu) || (op == OpLwu);
  assign is_store   = (op == OpSb) || (op == OpSh) || (op == OpSw);
  assign is_zext    = (op == OpAndi) || (op == OpOri) || (op == OpXori);
  // rt is read (not written) by R-type ALU ops, branches and stores.
  assign rt_src     = is_alu_r || is_beq || is_bne || is_store;

  logic [1:0]  mem_size;
  logic        mem_uns;
  logic [10:0] ctrl;

  always_comb begin
    // Low opcode bits encode the access size for all loads and stores; bit 2 marks unsigned loads.
    mem_size = (op[1:0] == 2'b00) ? 2'b00 : (op[1:0] == 2'b01) ? 2'b01 : 2'b11;
    mem_uns  = is_load && op[2];
    ctrl     = '0;
    if (is_alu_r)      ctrl = 11'h606;
    else if (is_jalr)  ctrl = 11'h604;
    // Link value pc4+4 is computed by the ALU, so link writes take the ALU result.
    else if (is_jal)   ctrl = 11'h600;
    else if (is_ialu)  ctrl = 11'h60B;
    else if (is_load)  ctrl = {1'b1, 1'b0, 1'b1, 1'b0, mem_uns, mem_size, 1'b1, 1'b0, 2'b00};
    else if (is_store) ctrl = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mem_size, 1'b1, 1'b0, 2'b00};
  end

  // ---------------------------------------------------------------------------------------------
  // Register file with write-through from WB
  // ---------------------------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (i_wb_we && (i_wb_reg != '0)) begin
      rf_q[i_wb_reg] <= i_wb_data;
    end
  end

  logic [DATA_W-1:0] rs_rf, rt_rf;

  always_comb begin
    rs_rf = rf_q[rs_idx];
    if (i_wb_we && (i_wb_reg == rs_idx)) rs_rf = i_wb_data;
    if (rs_idx == '0) rs_rf = '0;
    rt_rf = rf_q[rt_idx];
    if (i_wb_we && (i_wb_reg == rt_idx)) rt_rf = i_wb_data;
    if (rt_idx == '0) rt_rf = '0;
  end

  // ---------------------------------------------------------------------------------------------
  // Hazard detection and branch operands
  // ---------------------------------------------------------------------------------------------
  logic ex_rs, ex_rt, mem_rs, mem_rt, mem_rs_stall, mem_rt_stall;
  logic [DATA_W-1:0] rs_br, rt_br;

  assign ex_rs  = i_ex_we && (i_ex_dst != '0) && (i_ex_dst == rs_idx);
  assign ex_rt  = i_ex_we && (i_ex_dst != '0) && (i_ex_dst == rt_idx);
  assign mem_rs = i_mem_we && (i_mem_dst != '0) && (i_mem_dst == rs_idx);
  assign mem_rt = i_mem_we && (i_mem_dst != '0) && (i_mem_dst == rt_idx);

`ifdef ID_BRANCH_FWD_EN
  // A MEM ALU result is already available; only a MEM load still has to wait.
  assign mem_rs_stall = mem_rs && i_mem_read;
  assign mem_rt_stall = mem_rt && i_mem_read;
  assign rs_br        = (mem_rs && !i_mem_read) ? i_mem_data : rs_rf;
  assign rt_br        = (mem_rt && !i_mem_read) ? i_mem_data : rt_rf;
`else
  assign mem_rs_stall = mem_rs;
  assign mem_rt_stall = mem_rt;
  assign rs_br        = rs_rf;
  assign rt_br        = rt_rf;
  logic unused_mem;
  assign unused_mem = ^{i_mem_data, i_mem_read};
`endif

  logic load_use, br_stall, hazard, br_eq, jump_kind;
  logic halt_q;

  assign load_use  = i_ex_mem_read && (i_ex_dst != '0) &&
                     ((i_ex_dst == rs_idx) || (rt_src && (i_ex_dst == rt_idx)));
  assign br_stall  = ((is_beq || is_bne || is_jr || is_jalr) && (ex_rs || mem_rs_stall)) ||
                     ((is_beq || is_bne) && (ex_rt || mem_rt_stall));
  assign hazard    = load_use || br_stall;
  assign br_eq     = (rs_br == rt_br);
  assign jump_kind = is_j || is_jal || is_jr || is_jalr || (is_beq && br_eq) ||
                     (is_bne && !br_eq);

  assign o_stall = i_valid && !halt_q && hazard;
  assign o_jump  = i_valid && !o_stall && !halt_q && jump_kind;

  logic [31:0] imm_sext32;
  assign imm_sext32 = {{16{i_instruction[15]}}, i_instruction[15:0]};

  always_comb begin
    o_jump_addr = i_pc4 + {imm_sext32[29:0], 2'b00};
    if (is_j || is_jal)        o_jump_addr = {i_pc4[31:28], i_instruction[25:0], 2'b00};
    else if (is_jr || is_jalr) o_jump_addr = rs_br[31:0];
  end

  // ---------------------------------------------------------------------------------------------
  // ID/EX register and sticky halt
  // ---------------------------------------------------------------------------------------------
  logic              bubble, halt_d;
  logic              valid_q;
  logic [10:0]       ctrl_q;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] ra_q, rb_q, imm_q, ra_d, rb_d, imm_d;

  // HALT enters ID/EX as a bubble as well.
  assign bubble = i_flush || o_stall || !i_valid || halt_q || is_halt;
  assign halt_d = halt_q || (i_valid && is_halt && !hazard);

  always_comb begin
    ra_d    = rs_rf;
    rb_d    = rt_rf;
    instr_d = i_instruction;
    if (is_jal || is_jalr) begin
      ra_d = DATA_W'(i_pc4);
      rb_d = DATA_W'(32'd4);
    end
    if (is_jal) instr_d = {i_instruction[31:21], 5'd31, i_instruction[15:0]};
    imm_d = is_zext ? DATA_W'({16'h0000, i_instruction[15:0]})
                    : {{(DATA_W-16){i_instruction[15]}}, i_instruction[15:0]};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      instr_q <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
    end else begin
      halt_q <= halt_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      imm_q  <= imm_d;
      if (bubble) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        instr_q <= '0;
      end else begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl;
        instr_q <= instr_d;
      end
    end
  end

  assign o_halt  = halt_q;
  assign o_valid = valid_q;
  assign o_ctrl  = ctrl_q;
  assign o_instr = instr_q;
  assign o_RA    = ra_q;
  assign o_RB    = rb_q;
  assign o_imm   = imm_q;

endmodule

// File: tb/tb_decode_stage_hazard.sv
// Self-checking bench for decode_stage_hazard (32-bit data, 32 registers).
// ID/EX expectations are queued when an instruction is driven and compared one cycle later.
module tb_decode_stage_hazard;

  logic        i_clk, i_reset, i_valid, i_flush, i_wb_we;
  logic        i_ex_mem_read, i_ex_we, i_mem_read, i_mem_we;
  logic [31:0] i_pc4, i_instruction, i_wb_data, i_mem_data;
  logic [4:0]  i_wb_reg, i_ex_dst, i_mem_dst;
  logic        o_stall, o_jump, o_halt, o_valid;
  logic [31:0] o_jump_addr, o_RA, o_RB, o_imm, o_instr;
  logic [10:0] o_ctrl;

  decode_stage_hazard #(.DATA_W(32), .NUM_REGS(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_pc4(i_pc4),
    .i_instruction(i_instruction), .i_flush(i_flush), .i_wb_we(i_wb_we),
    .i_wb_reg(i_wb_reg), .i_wb_data(i_wb_data), .i_ex_mem_read(i_ex_mem_read),
    .i_ex_we(i_ex_we), .i_ex_dst(i_ex_dst), .i_mem_read(i_mem_read), .i_mem_we(i_mem_we),
    .i_mem_dst(i_mem_dst), .i_mem_data(i_mem_data), .o_stall(o_stall), .o_jump(o_jump),
    .o_jump_addr(o_jump_addr), .o_halt(o_halt), .o_valid(o_valid), .o_RA(o_RA), .o_RB(o_RB),
    .o_imm(o_imm), .o_instr(o_instr), .o_ctrl(o_ctrl)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic        chk_ctrl;
    logic [10:0] ctrl;
    logic [31:0] instr;
    logic        chk_data;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] imm;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  // Scoreboard consumer: one expectation per cycle, sampled just after the edge.
  always @(posedge i_clk) begin : monitor
    exp_t  e;
    string n;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (o_valid !== e.valid) begin
        errors++;
        $display("FAIL %s o_valid: got %0b expected %0b", n, o_valid, e.valid);
      end
      checks++;
      if (o_instr !== e.instr) begin
        errors++;
        $display("FAIL %s o_instr: got %h expected %h", n, o_instr, e.instr);
      end
      if (e.chk_ctrl) begin
        checks++;
        if (o_ctrl !== e.ctrl) begin
          errors++;
          $display("FAIL %s o_ctrl: got %h expected %h", n, o_ctrl, e.ctrl);
        end
      end
      if (e.chk_data) begin
        checks++;
        if (o_RA !== e.ra) begin
          errors++;
          $display("FAIL %s o_RA: got %h expected %h", n, o_RA, e.ra);
        end
        checks++;
        if (o_RB !== e.rb) begin
          errors++;
          $display("FAIL %s o_RB: got %h expected %h", n, o_RB, e.rb);
        end
        checks++;
        if (o_imm !== e.imm) begin
          errors++;
          $display("FAIL %s o_imm: got %h expected %h", n, o_imm, e.imm);
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    if (ins[31:26] == 6'h0C || ins[31:26] == 6'h0D || ins[31:26] == 6'h0E)
      return {16'h0000, ins[15:0]};
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  task automatic push_bubble(input string n);
    exp_t e;
    e = '{valid: 1'b0, chk_ctrl: 1'b1, ctrl: 11'h0, instr: 32'h0, chk_data: 1'b0,
          ra: 32'h0, rb: 32'h0, imm: 32'h0};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic push_instr(input string n, input logic chk_ctrl, input logic [10:0] ctrl,
                            input logic [31:0] instr, input logic chk_data,
                            input logic [31:0] ra, input logic [31:0] rb);
    exp_t e;
    e = '{valid: 1'b1, chk_ctrl: chk_ctrl, ctrl: ctrl, instr: instr, chk_data: chk_data,
          ra: ra, rb: rb, imm: exp_imm(instr)};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic clear_inputs();
    i_valid = 1'b0; i_pc4 = 32'd4; i_instruction = 32'h0; i_flush = 1'b0;
    i_wb_we = 1'b0; i_wb_reg = 5'd0; i_wb_data = 32'h0;
    i_ex_mem_read = 1'b0; i_ex_we = 1'b0; i_ex_dst = 5'd0;
    i_mem_read = 1'b0; i_mem_we = 1'b0; i_mem_dst = 5'd0; i_mem_data = 32'h0;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc4);
    i_valid = 1'b1; i_instruction = ins; i_pc4 = pc4;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    clear_inputs();
    #1 i_reset = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b halt=%b expected 0 0", o_valid, o_halt);
    end
    checks++;
    if (o_ctrl !== 11'h0 || o_instr !== 32'h0 || o_RA !== 32'h0 || o_RB !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: ctrl=%h instr=%h RA=%h RB=%h expected all 0",
               o_ctrl, o_instr, o_RA, o_RB);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] add;
    add = enc_r(5, 6, 31, 6'h20);
    @(negedge i_clk); i_wb_we = 1'b1; i_wb_reg = 5'd5; i_wb_data = 32'd5;
    @(negedge i_clk); i_wb_reg = 5'd6; i_wb_data = 32'd6;
    @(negedge i_clk); i_wb_we = 1'b0; drive(add, 32'd4);
    #1;
    checks++;
    if (o_stall !== 1'b0 || o_jump !== 1'b0) begin
      errors++;
      $display("FAIL basic_comb: stall=%b jump=%b expected 0 0", o_stall, o_jump);
    end
    push_instr("basic_add", 1'b1, 11'h606, add, 1'b1, 32'd5, 32'd6);
    @(negedge i_clk); i_valid = 1'b0;
    push_bubble("basic_idle");
  endtask

  task automatic test_load_use();
    logic [31:0] add, addi, add0;
    add  = enc_r(5, 6, 31, 6'h20);
    addi = enc_i(6'h08, 5, 6, 16'd1);
    add0 = enc_r(0, 6, 31, 6'h20);
    @(negedge i_clk); i_ex_mem_read = 1'b1; i_ex_dst = 5'd5; drive(add, 32'd4);
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      errors++; $display("FAIL lu_rs_stall: got %b expected 1", o_stall);
    end
    push_bubble("lu_rs_bubble");
    @(negedge i_clk); i_ex_mem_read = 1'b0;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL lu_release: got %b expected 0", o_stall);
    end
    push_instr("lu_issue", 1'b1, 11'h606, add, 1'b1, 32'd5, 32'd6);
    // rt of an I-type is a destination, so it must not stall.
    @(negedge i_clk); i_ex_mem_read = 1'b1; i_ex_dst = 5'd6; drive(addi, 32'd4);
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL lu_rt_dst: got %b expected 0", o_stall);
    end
    push_instr("lu_addi", 1'b1, 11'h60B, addi, 1'b1, 32'd5, 32'd6);
    @(negedge i_clk); i_ex_dst = 5'd0; drive(add0, 32'd4);
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL lu_r0: got %b expected 0", o_stall);
    end
    push_instr("lu_r0_add", 1'b1, 11'h606, add0, 1'b1, 32'd0, 32'd6);
    @(negedge i_clk); i_ex_dst = 5'd6; drive(add, 32'd4);
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      errors++; $display("FAIL lu_rt_src: got %b expected 1", o_stall);
    end
    push_bubble("lu_rt_bubble");
    @(negedge i_clk); clear_inputs();
  endtask

  task automatic test_bypass();
    logic [31:0] a56, a06, a05;
    a56 = enc_r(5, 6, 31, 6'h20);
    a06 = enc_r(0, 6, 31, 6'h20);
    a05 = enc_r(0, 5, 31, 6'h20);
    @(negedge i_clk); i_wb_we = 1'b1; i_wb_reg = 5'd5; i_wb_data = 32'hA; drive(a56, 32'd4);
    push_instr("byp_rs", 1'b1, 11'h606, a56, 1'b1, 32'hA, 32'd6);
    @(negedge i_clk); i_wb_reg = 5'd0; i_wb_data = 32'h55; drive(a06, 32'd4);
    push_instr("byp_r0", 1'b1, 11'h606, a06, 1'b1, 32'd0, 32'd6);
    @(negedge i_clk); i_wb_we = 1'b0; drive(a05, 32'd4);
    push_instr("byp_written", 1'b1, 11'h606, a05, 1'b1, 32'd0, 32'hA);
    @(negedge i_clk); i_wb_we = 1'b1; i_wb_reg = 5'd5; i_wb_data = 32'd5; i_valid = 1'b0;
    push_bubble("byp_restore");
    @(negedge i_clk); clear_inputs();
  endtask

  task automatic test_decode();
    logic [31:0] ins [4];
    logic [10:0] ctl [4];
    ins[0] = enc_i(6'h08, 5, 7, 16'h8000); ctl[0] = 11'h60B;
    ins[1] = enc_i(6'h0C, 5, 7, 16'h8000); ctl[1] = 11'h60B;
    ins[2] = enc_i(6'h25, 5, 7, 16'hFFFC); ctl[2] = 11'h558;
    ins[3] = enc_i(6'h2B, 5, 6, 16'h0004); ctl[3] = 11'h0B8;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk); drive(ins[k], 32'd4);
      push_instr($sformatf("dec_%0d", k), 1'b1, ctl[k], ins[k], 1'b1, 32'd5,
                 (k == 3) ? 32'd6 : 32'd0);
    end
    @(negedge i_clk); clear_inputs();
  endtask

  task automatic test_branch();
    logic [31:0] bne, beq, bneg, j, jal, jr, jalr;
    bne  = enc_i(6'h05, 5, 6, 16'd4);
    beq  = enc_i(6'h04, 5, 6, 16'd4);
    bneg = enc_i(6'h05, 5, 6, 16'hFFFE);
    j    = {6'h02, 26'h3FF_FFFF};
    jal  = {6'h03, 26'd10};
    jr   = enc_r(5, 0, 0, 6'h08);
    jalr = enc_r(5, 0, 31, 6'h09);
    @(negedge i_clk); drive(bne, 32'd4); #1;
    checks++;
    if (o_jump !== 1'b1 || o_jump_addr !== 32'h14) begin
      errors++; $display("FAIL br_bne: jump=%b addr=%h expected 1 00000014", o_jump, o_jump_addr);
    end
    push_instr("br_bne", 1'b1, 11'h0, bne, 1'b1, 32'd5, 32'd6);
    @(negedge i_clk); drive(beq, 32'd4); #1;
    checks++;
    if (o_jump !== 1'b0) begin
      errors++; $display("FAIL br_beq: jump=%b expected 0", o_jump);
    end
    push_instr("br_beq", 1'b1, 11'h0, beq, 1'b1, 32'd5, 32'd6);
    @(negedge i_clk); drive(bneg, 32'h100); #1;
    checks++;
    if (o_jump !== 1'b1 || o_jump_addr !== 32'hF8) begin
      errors++; $display("FAIL br_neg: jump=%b addr=%h expected 1 000000f8", o_jump, o_jump_addr);
    end
    push_instr("br_neg", 1'b1, 11'h0, bneg, 1'b1, 32'd5, 32'd6);
    @(negedge i_clk); drive(j, 32'hA000_0004); #1;
    checks++;
    if (o_jump !== 1'b1 || o_jump_addr !== 32'hAFFF_FFFC) begin
      errors++; $display("FAIL br_j: jump=%b addr=%h expected 1 affffffc", o_jump, o_jump_addr);
    end
    push_instr("br_j", 1'b1, 11'h0, j, 1'b0, 32'd0, 32'd0);
    @(negedge i_clk); drive(jal, 32'd4); #1;
    checks++;
    if (o_jump !== 1'b1 || o_jump_addr !== 32'h28) begin
      errors++; $display("FAIL br_jal: jump=%b addr=%h expected 1 00000028", o_jump, o_jump_addr);
    end
    push_instr("br_jal", 1'b0, 11'h0, 32'h0C1F_000A, 1'b1, 32'd4, 32'd4);
    @(negedge i_clk); drive(jr, 32'd4); #1;
    checks++;
    if (o_jump !== 1'b1 || o_jump_addr !== 32'd5) begin
      errors++; $display("FAIL br_jr: jump=%b addr=%h expected 1 00000005", o_jump, o_jump_addr);
    end
    push_instr("br_jr", 1'b1, 11'h0, jr, 1'b1, 32'd5, 32'd0);
    @(negedge i_clk); drive(jalr, 32'd8); #1;
    checks++;
    if (o_jump !== 1'b1 || o_jump_addr !== 32'd5) begin
      errors++; $display("FAIL br_jalr: jump=%b addr=%h expected 1 00000005", o_jump, o_jump_addr);
    end
    push_instr("br_jalr", 1'b0, 11'h0, jalr, 1'b1, 32'd8, 32'd4);
    @(negedge i_clk); drive(bne, 32'd4); i_valid = 1'b0; #1;
    checks++;
    if (o_jump !== 1'b0) begin
      errors++; $display("FAIL br_invalid: jump=%b expected 0", o_jump);
    end
    @(negedge i_clk); clear_inputs();
  endtask

  task automatic test_branch_fwd();
    logic [31:0] beq, bne, beq0;
    beq  = enc_i(6'h04, 5, 6, 16'd4);
    bne  = enc_i(6'h05, 5, 6, 16'd4);
    beq0 = enc_i(6'h04, 0, 0, 16'd1);
    @(negedge i_clk);
    i_mem_we = 1'b1; i_mem_dst = 5'd5; i_mem_data = 32'd6; drive(beq, 32'd4); #1;
`ifdef ID_BRANCH_FWD_EN
    checks++;
    if (o_stall !== 1'b0 || o_jump !== 1'b1 || o_jump_addr !== 32'h14) begin
      errors++;
      $display("FAIL fwd_mem_alu: stall=%b jump=%b addr=%h expected 0 1 00000014",
               o_stall, o_jump, o_jump_addr);
    end
    push_instr("fwd_mem_alu", 1'b1, 11'h0, beq, 1'b0, 32'd0, 32'd0);
`else
    checks++;
    if (o_stall !== 1'b1 || o_jump !== 1'b0) begin
      errors++;
      $display("FAIL fwd_mem_alu: stall=%b jump=%b expected 1 0", o_stall, o_jump);
    end
    push_bubble("fwd_mem_alu");
`endif
    @(negedge i_clk); i_mem_read = 1'b1; #1;
    checks++;
    if (o_stall !== 1'b1 || o_jump !== 1'b0) begin
      errors++; $display("FAIL fwd_mem_load: stall=%b jump=%b expected 1 0", o_stall, o_jump);
    end
    push_bubble("fwd_mem_load");
    @(negedge i_clk);
    i_mem_read = 1'b0; i_mem_we = 1'b0; i_ex_we = 1'b1; i_ex_dst = 5'd6; drive(bne, 32'd4); #1;
    checks++;
    if (o_stall !== 1'b1 || o_jump !== 1'b0) begin
      errors++; $display("FAIL fwd_ex_dep: stall=%b jump=%b expected 1 0", o_stall, o_jump);
    end
    push_bubble("fwd_ex_dep");
    @(negedge i_clk);
    i_ex_dst = 5'd0; i_mem_we = 1'b1; i_mem_dst = 5'd0; drive(beq0, 32'd8); #1;
    checks++;
    if (o_stall !== 1'b0 || o_jump !== 1'b1 || o_jump_addr !== 32'hC) begin
      errors++;
      $display("FAIL fwd_r0: stall=%b jump=%b addr=%h expected 0 1 0000000c",
               o_stall, o_jump, o_jump_addr);
    end
    push_instr("fwd_r0", 1'b1, 11'h0, beq0, 1'b1, 32'd0, 32'd0);
    @(negedge i_clk); clear_inputs();
  endtask

  task automatic test_flush();
    @(negedge i_clk); i_flush = 1'b1; drive(enc_r(5, 6, 31, 6'h20), 32'd4);
    push_bubble("flush");
    @(negedge i_clk); clear_inputs();
  endtask

  task automatic test_halt();
    logic [31:0] add;
    add = enc_r(5, 6, 31, 6'h20);
    @(negedge i_clk); drive(32'hFFFF_FFFF, 32'd4); #1;
    checks++;
    if (o_halt !== 1'b0 || o_stall !== 1'b0) begin
      errors++; $display("FAIL halt_pre: halt=%b stall=%b expected 0 0", o_halt, o_stall);
    end
    push_bubble("halt_instr");
    @(posedge i_clk); #2;
    checks++;
    if (o_halt !== 1'b1) begin
      errors++; $display("FAIL halt_set: got %b expected 1", o_halt);
    end
    @(negedge i_clk); i_ex_mem_read = 1'b1; i_ex_dst = 5'd5; drive(add, 32'd4); #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL halt_no_stall: got %b expected 0", o_stall);
    end
    push_bubble("halt_add");
    @(negedge i_clk); i_ex_mem_read = 1'b0; drive(enc_i(6'h05, 5, 6, 16'd4), 32'd4); #1;
    checks++;
    if (o_jump !== 1'b0 || o_halt !== 1'b1 || o_RA !== 32'd5) begin
      errors++;
      $display("FAIL halt_no_jump: jump=%b halt=%b RA=%h expected 0 1 00000005",
               o_jump, o_halt, o_RA);
    end
    push_bubble("halt_bne");
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if (o_halt !== 1'b0 || o_RA !== 32'd0) begin
      errors++; $display("FAIL halt_async_reset: halt=%b RA=%h expected 0 0", o_halt, o_RA);
    end
    @(negedge i_clk); i_reset = 1'b1; clear_inputs(); drive(add, 32'd4);
    push_instr("post_reset_rf", 1'b1, 11'h606, add, 1'b1, 32'd0, 32'd0);
    @(negedge i_clk); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_use();
    test_bypass();
    test_decode();
    test_branch();
    test_branch_fwd();
    test_flush();
    test_halt();
    repeat (2) @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
